mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between two requesters: instruction fetch (IR load path) and data access (MAR/MDR load/store path) of the multicycle RV32I core. It arbitrates with two-way round-robin and issues one access per grant. For reads it waits a fixed memory latency, then returns registered read data with a one-cycle valid pulse. It sits between control_unit-driven datapath registers and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles from the issue cycle to valid mem_rdata; legal range 1..7

Ports:
- ctrl_clk  in  1  clock; all state updates on the rising edge
- ctrl_rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted (issue cycle)
- if_valid  out  1  one-cycle pulse: if_rdata updated
- if_rdata  out  DATA_W  registered fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted (issue cycle)
- d_valid  out  1  one-cycle pulse: d_rdata updated (loads only)
- d_rdata  out  DATA_W  registered load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state is not IDLE

## Operation
- States: IDLE, RD_WAIT, RESP.
- IDLE, no request: all memory strobes are 0.
- IDLE, one request: that requester wins.
- IDLE, both requesting: the winner is the requester not granted last (last_owner). last_owner resets to data, so the first tie goes to fetch.
- Issue cycle: the winner's gnt is 1 (combinational). mem_en=1. mem_addr, mem_we and mem_wdata come combinationally from the winner's inputs; fetch always has mem_we=0. last_owner updates to the winner.
- Store issue: the write completes in the issue cycle and the state stays IDLE. A new grant is possible the next cycle. No d_valid is generated.
- Read issue: lat_cnt loads RD_LAT-1 and the state goes to RD_WAIT.
- RD_WAIT: lat_cnt decrements each cycle. On the edge where lat_cnt==0, mem_rdata is captured into the owner's rdata register and the state goes to RESP.
- RESP: the owner's valid is 1 for one cycle, then the state goes to IDLE. No grants are issued in RD_WAIT or RESP.
- Requests during busy: gnt stays 0. The requester holds req, addr and wdata stable until it sees gnt.
- Requester protocol: a requester drops req the cycle after gnt unless it wants another access.
- Non-owner rdata: the register holds its value and that requester's valid stays 0.
- Addresses pass through unmodified; alignment is the memory's concern.

## Timing
- Reset values: state=IDLE, last_owner=data, lat_cnt=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0, busy=0. With no request, all gnt and mem_* outputs are 0.
- Read latency: valid asserts RD_LAT+1 cycles after the gnt cycle. With RD_LAT=1, gnt at cycle t gives mem_rdata sampled at the end of t+1 and valid at t+2.
- Read throughput: one read per RD_LAT+2 cycles.
- Store throughput: one store per cycle.
- Reset mid-read: the outstanding read is dropped, no valid is produced, and rdata registers clear to 0.
- An rdata register changes only on the capture edge that precedes its valid.
- mem_rdata is ignored outside the capture edge.
- A req asserted in the RESP cycle is granted at the earliest in the following IDLE cycle.

## Structure
- Package mem_arb_pkg:
  - state encoding: IDLE=2'd0, RD_WAIT=2'd1, RESP=2'd2
  - owner encoding: OWN_IF=1'b0, OWN_D=1'b1
  - LAT_CNT_W=3
- Sub-module rr_arb2: two-request round-robin picker, combinational pick plus a last_owner register with its own async reset.
- The top level holds the FSM, latency counter and capture registers.

## Test plan
- Single fetch, RD_LAT=1: if_addr=0x0000_0004 with memory returning 0x0051_0093. Expect if_gnt at t, mem_en=1 and mem_addr=0x4 at t, if_valid at t+2, and if_rdata=0x0051_0093 held afterward.
- Simultaneous requests from reset: if_req=d_req=1 (load, 0x100). Fetch wins first. The load is granted in the first IDLE cycle after fetch RESP, and d_valid returns the memory word at 0x100.
- Fairness: both reqs held high for 6 grants. Grant order is IF, D, IF, D, IF, D and neither side starves.
- Back-to-back stores: d_we=1 at 0x200 then 0x204, data 0xDEAD_BEEF then 0x1234_5678. Expect d_gnt in consecutive cycles, mem_we=1 both cycles, and no d_valid.
- RD_LAT=3: a fetch gives valid exactly 4 cycles after gnt. if_gnt stays 0 while busy=1, even with if_req held.
- Reset during RD_WAIT: assert ctrl_rst one cycle after a read gnt. Expect valid never pulses, rdata=0, state IDLE, and the next tie goes to fetch.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Owner encoding doubles as the round-robin history bit.
package mem_arb_pkg;

  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Counter preload for a read: RD_LAT-1 further cycles after the issue cycle.
  function automatic logic [LAT_CNT_W-1:0] lat_preload(input int rd_lat);
    return LAT_CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker: combinational pick and a last-owner register.
// On a tie the requester that was not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_if,
  input  logic i_req_d,
  input  logic i_en,
  output logic o_pick_if,
  output logic o_pick_d
);

  owner_t r_last_owner;

  always_comb begin
    o_pick_if = 1'b0;
    o_pick_d  = 1'b0;
    if (i_req_if && i_req_d) begin
      if (r_last_owner == OWN_D) o_pick_if = 1'b1;
      else                       o_pick_d  = 1'b1;
    end else begin
      o_pick_if = i_req_if;
      o_pick_d  = i_req_d;
    end
  end

  // History only moves when a grant is actually issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_owner <= OWN_D;
    end else if (i_en && o_pick_if) begin
      r_last_owner <= OWN_IF;
    end else if (i_en && o_pick_d) begin
      r_last_owner <= OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Stores complete in the issue cycle; reads wait RD_LAT cycles and return registered data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = lat_preload(RD_LAT);

  arb_state_t            r_state;
  owner_t                r_owner;
  logic [LAT_CNT_W-1:0]  r_lat_cnt;
  logic [DATA_W-1:0]     r_if_rdata;
  logic [DATA_W-1:0]     r_d_rdata;
  logic                  r_if_valid;
  logic                  r_d_valid;

  logic                  w_idle;
  logic                  w_pick_if;
  logic                  w_pick_d;
  logic                  w_if_gnt;
  logic                  w_d_gnt;
  logic                  w_store;
  logic                  w_read_issue;

  assign w_idle = (r_state == IDLE);

  rr_arb2 u_rr_arb2 (
    .i_clk     (ctrl_clk),
    .i_rst     (ctrl_rst),
    .i_req_if  (if_req),
    .i_req_d   (d_req),
    .i_en      (w_idle),
    .o_pick_if (w_pick_if),
    .o_pick_d  (w_pick_d)
  );

  // Grants and memory strobes are combinational and only exist while idle.
  assign w_if_gnt     = w_idle && w_pick_if;
  assign w_d_gnt      = w_idle && w_pick_d;
  assign w_store      = w_d_gnt && d_we;
  assign w_read_issue = w_if_gnt || (w_d_gnt && !d_we);

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_en    = w_if_gnt || w_d_gnt;
  assign mem_we    = w_store;
  assign mem_addr  = w_d_gnt ? d_addr : (w_if_gnt ? if_addr : '0);
  assign mem_wdata = w_store ? d_wdata : '0;

  assign busy     = !w_idle;
  assign if_valid = r_if_valid;
  assign d_valid  = r_d_valid;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

  always_ff @(posedge ctrl_clk or posedge ctrl_rst) begin
    if (ctrl_rst) begin
      r_state    <= IDLE;
      r_owner    <= OWN_D;
      r_lat_cnt  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_read_issue) begin
            r_owner   <= w_if_gnt ? OWN_IF : OWN_D;
            r_lat_cnt <= LAT_INIT;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // mem_rdata is only trusted on this edge; valid follows in RESP.
          if (r_lat_cnt == '0) begin
            if (r_owner == OWN_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_valid <= 1'b1;
            end else begin
              r_d_rdata <= mem_rdata;
              r_d_valid <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-level transaction model plus directed and random stimulus.
// A second instance with RD_LAT=3 covers the longer latency path.
module tb_mem_port_arbiter;

  localparam int L = 1;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_rst = 1'b1;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_valid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  logic        if_req_3 = 1'b0;
  logic [31:0] if_addr_3 = '0;
  logic        if_gnt_3, if_valid_3;
  logic [31:0] if_rdata_3;
  logic        d_gnt_3, d_valid_3;
  logic [31:0] d_rdata_3;
  logic        mem_en_3, mem_we_3;
  logic [31:0] mem_addr_3, mem_wdata_3;
  logic [31:0] mem_rdata_3 = '0;
  logic        busy_3;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(L)) u_dut (
    .ctrl_clk(ctrl_clk), .ctrl_rst(ctrl_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .ctrl_clk(ctrl_clk), .ctrl_rst(ctrl_rst),
    .if_req(if_req_3), .if_addr(if_addr_3), .if_gnt(if_gnt_3), .if_valid(if_valid_3), .if_rdata(if_rdata_3),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_gnt(d_gnt_3), .d_valid(d_valid_3), .d_rdata(d_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata_3), .busy(busy_3)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int cyc = 0;
  always @(posedge ctrl_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [31:0] mem_arr [logic [31:0]];

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  // Transaction model: a read issued in cycle c keeps the port busy until c+L+2,
  // delivers valid in cycle c+L+1, and the memory presents data only in cycle c+L.
  int          m_free = 0;
  int          m_vcyc = -1;
  logic        m_last = 1'b1;
  logic        m_vown = 1'b0;
  logic [31:0] m_vdata = '0;
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_d_rd = '0;
  int          rd_due = -1;
  logic [31:0] rd_addr = '0;

  always @(negedge ctrl_clk) begin : cmp_proc
    logic e_if, e_d, idle;
    int   c;
    c = cyc;
    if (ctrl_rst) begin
      m_free = c; m_vcyc = -1; m_last = 1'b1; m_if_rd = '0; m_d_rd = '0; rd_due = -1;
      chk("rst_busy", busy, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_gnt", {if_gnt, d_gnt}, 0);
    end else begin
      if (c == m_vcyc) begin
        if (m_vown) m_d_rd = m_vdata;
        else        m_if_rd = m_vdata;
      end
      idle = (c >= m_free);
      e_if = idle && if_req && (!d_req || m_last);
      e_d  = idle && d_req && (!if_req || !m_last);
      chk("if_gnt", if_gnt, e_if);
      chk("d_gnt", d_gnt, e_d);
      chk("busy", busy, !idle);
      chk("mem_en", mem_en, e_if || e_d);
      chk("if_valid", if_valid, (c == m_vcyc) && !m_vown);
      chk("d_valid", d_valid, (c == m_vcyc) && m_vown);
      chk("if_rdata", if_rdata, m_if_rd);
      chk("d_rdata", d_rdata, m_d_rd);
      if (e_if) begin
        chk("if_mem_addr", mem_addr, if_addr);
        chk("if_mem_we", mem_we, 0);
      end
      if (e_d) begin
        chk("d_mem_addr", mem_addr, d_addr);
        chk("d_mem_we", mem_we, d_we);
        if (d_we) chk("d_mem_wdata", mem_wdata, d_wdata);
      end
      if (idle && !if_req && !d_req)
        chk("idle_mem_bus", {mem_we, mem_addr ^ mem_wdata, mem_addr}, 0);
      if (e_if || e_d) begin
        m_last = e_d;
        if (e_if || !d_we) begin
          m_free  = c + L + 2;
          m_vcyc  = c + L + 1;
          m_vown  = e_d;
          m_vdata = mem_read(e_d ? d_addr : if_addr);
        end
      end
    end
    if (!ctrl_rst && mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    mem_rdata = (c == rd_due) ? mem_read(rd_addr) : $urandom;
    if (!ctrl_rst && mem_en && !mem_we) begin
      rd_due  = c + L;
      rd_addr = mem_addr;
    end
  end

  // The RD_LAT=3 memory tags each cycle's data with the cycle number.
  always @(negedge ctrl_clk) mem_rdata_3 = 32'h3000_0000 | 32'(cyc);

  task automatic nxt();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic samp();
    @(negedge ctrl_clk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    ctrl_rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    nxt();
    ctrl_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic own[6];
    int   n_g;
    int   cg;
    logic g_if, g_d;

    mem_arr[32'h0000_0004] = 32'h0051_0093;
    mem_arr[32'h0000_0100] = 32'hCAFE_0100;
    repeat (2) nxt();
    ctrl_rst = 1'b0;

    // Single fetch, RD_LAT=1
    nxt(); if_req = 1'b1; if_addr = 32'h4;
    samp(); chk("t1_gnt", if_gnt, 1); chk("t1_mem_en", mem_en, 1); chk("t1_addr", mem_addr, 32'h4);
    nxt(); if_req = 1'b0;
    samp(); chk("t1_valid_early", if_valid, 0); chk("t1_busy", busy, 1);
    nxt();
    samp(); chk("t1_valid", if_valid, 1); chk("t1_rdata", if_rdata, 32'h0051_0093);
    nxt();
    samp(); chk("t1_valid_drop", if_valid, 0); chk("t1_rdata_hold", if_rdata, 32'h0051_0093);

    // Tie from reset: fetch first, then the load in the first IDLE cycle
    do_reset();
    nxt(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    samp(); chk("t2_if_first", {if_gnt, d_gnt}, 2'b10);
    nxt(); if_req = 1'b0;
    samp(); chk("t2_d_wait1", d_gnt, 0);
    nxt();
    samp(); chk("t2_d_wait_resp", d_gnt, 0); chk("t2_if_valid", if_valid, 1);
    nxt();
    samp(); chk("t2_d_gnt", d_gnt, 1);
    nxt(); d_req = 1'b0;
    samp();
    nxt();
    samp(); chk("t2_d_valid", d_valid, 1); chk("t2_d_rdata", d_rdata, 32'hCAFE_0100);

    // Fairness with both requests held
    nxt(); if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    n_g = 0;
    for (int k = 0; k < 60 && n_g < 6; k++) begin
      samp();
      if (if_gnt || d_gnt) begin
        own[n_g] = d_gnt;
        n_g++;
      end
      if (n_g < 6) nxt();
    end
    nxt(); if_req = 1'b0; d_req = 1'b0;
    chk("t3_grant_count", n_g, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("t3_order_%0d", k), own[k], k % 2);
    repeat (4) nxt();

    // Back-to-back stores
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    samp(); chk("t4_gnt0", d_gnt, 1); chk("t4_we0", mem_we, 1);
    chk("t4_addr0", mem_addr, 32'h200); chk("t4_wdata0", mem_wdata, 32'hDEAD_BEEF);
    nxt(); d_addr = 32'h204; d_wdata = 32'h1234_5678;
    samp(); chk("t4_gnt1", d_gnt, 1); chk("t4_we1", mem_we, 1);
    chk("t4_addr1", mem_addr, 32'h204); chk("t4_wdata1", mem_wdata, 32'h1234_5678);
    nxt(); d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      samp(); chk("t4_no_d_valid", d_valid, 0); chk("t4_idle", busy, 0);
      nxt();
    end

    // Reset during RD_WAIT
    if_req = 1'b1; if_addr = 32'h4;
    samp(); chk("t5_gnt", if_gnt, 1);
    nxt(); if_req = 1'b0; ctrl_rst = 1'b1;
    samp(); chk("t5_rst_busy", busy, 0);
    nxt(); ctrl_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      samp(); chk("t5_no_valid", if_valid, 0); chk("t5_rdata_clr", if_rdata, 0); chk("t5_idle", busy, 0);
      nxt();
    end
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    samp(); chk("t5_tie_fetch", {if_gnt, d_gnt}, 2'b10);
    nxt(); if_req = 1'b0; d_req = 1'b0;
    repeat (4) nxt();

    // RD_LAT=3 instance
    if_req_3 = 1'b1; if_addr_3 = 32'h8;
    samp(); chk("t6_gnt", if_gnt_3, 1); chk("t6_addr", mem_addr_3, 32'h8);
    cg = cyc;
    for (int k = 1; k <= 4; k++) begin
      nxt();
      samp(); chk("t6_no_gnt_busy", if_gnt_3, 0); chk("t6_busy", busy_3, 1);
      chk("t6_valid", if_valid_3, (k == 4));
      if (k == 4) chk("t6_rdata", if_rdata_3, 32'h3000_0000 | 32'(cg + 3));
    end
    nxt();
    samp(); chk("t6_regrant", if_gnt_3, 1);
    nxt(); if_req_3 = 1'b0;
    repeat (6) nxt();

    // Randomized traffic with occasional reset
    g_if = 1'b0; g_d = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k != 0) nxt();
      if (ctrl_rst) begin
        ctrl_rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        ctrl_rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
      end
      if (!ctrl_rst) begin
        if (!if_req || g_if) begin
          if_req  = ($urandom_range(0, 2) != 0);
          if_addr = 32'($urandom_range(0, 63)) << 2;
        end
        if (!d_req || g_d) begin
          d_req   = ($urandom_range(0, 2) != 0);
          d_we    = $urandom_range(0, 1) == 1;
          d_addr  = 32'($urandom_range(0, 63)) << 2;
          d_wdata = $urandom;
        end
      end
      samp();
      g_if = if_gnt; g_d = d_gnt;
    end
    nxt(); if_req = 1'b0; d_req = 1'b0;
    repeat (6) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
